pc_sequencer: RTL and testbench
===============================

PC_SEQUENCER -- requirements
Module: pc_sequencer

Interface
REQ-001 Parameter DATA_WIDTH_P, default 32: PC and target width in bits.
REQ-002 Parameter RESET_VECTOR_P, default 0: PC value loaded on reset.
REQ-003 Parameter TRAP_VECTOR_P, default 32'h0000_0100: PC value loaded on trap entry.
REQ-004 Parameter INSTR_BYTES_P, default 4 (power of two, >=2): sequential increment and alignment granule.
REQ-005 clk  in  1  sole clock; all state updates on posedge.
REQ-006 reset  in  1  asynchronous, active-high; clears all state immediately on assertion.
REQ-007 i_pc_ready  in  1  fetch stage accepts o_pc this cycle.
REQ-008 i_stall  in  1  freeze sequential advance.
REQ-009 i_redirect_valid  in  1  branch/jump taken.
REQ-010 i_redirect_target  in  DATA_WIDTH_P  branch/jump destination.
REQ-011 i_trap  in  1  exception request.
REQ-012 i_mret  in  1  return from trap.
REQ-013 i_halt / i_resume  in  1 each  debug halt / resume requests.
REQ-014 o_pc  out  DATA_WIDTH_P  current fetch address.
REQ-015 o_pc_valid  out  1  o_pc is a valid fetch request.
REQ-016 o_epc  out  DATA_WIDTH_P  saved exception PC.
REQ-017 o_misaligned  out  1  one-cycle pulse: misaligned redirect converted to trap.

Function
REQ-018 States SHALL be BOOT, RUN, HALTED; BOOT -> RUN unconditionally after one cycle.
REQ-019 o_pc_valid SHALL be 1 only in RUN; o_pc SHALL be a registered output.
REQ-020 Event priority per cycle SHALL be: trap (incl. misaligned redirect) > mret > redirect > sequential advance.
REQ-021 Sequential advance: in RUN, when o_pc_valid & i_pc_ready & !i_stall, o_pc SHALL become o_pc + INSTR_BYTES_P next cycle, modulo 2^DATA_WIDTH_P (wrap silently).
REQ-022 Without acceptance (ready low or stall high), o_pc SHALL hold its value; o_pc_valid SHALL remain high (no withdrawal).
REQ-023 Redirect: o_pc SHALL equal i_redirect_target next cycle, independent of i_pc_ready and i_stall.
REQ-024 Redirect with target bits [log2(INSTR_BYTES_P)-1:0] nonzero SHALL act as a trap instead and pulse o_misaligned for exactly one cycle.
REQ-025 Trap: o_epc SHALL capture current o_pc and o_pc SHALL become TRAP_VECTOR_P next cycle.
REQ-026 Mret: o_pc SHALL become o_epc next cycle; o_epc unchanged.
REQ-027 Simultaneous trap and mret: trap wins; o_epc captures current o_pc.
REQ-028 i_halt in RUN SHALL enter HALTED next cycle; any same-cycle PC update (advance/redirect/trap) SHALL still apply.
REQ-029 In HALTED, o_pc_valid=0, sequential advance disabled; redirect/trap/mret SHALL still update o_pc/o_epc per priority.
REQ-030 i_resume in HALTED SHALL enter RUN next cycle; i_resume outside HALTED SHALL be ignored; i_halt and i_resume together in HALTED: resume wins.
REQ-031 Inputs in BOOT other than reset SHALL be ignored.

Reset
REQ-032 On reset assertion (any cycle, mid-operation included): state=BOOT, o_pc=RESET_VECTOR_P, o_epc=0, o_pc_valid=0, o_misaligned=0, without waiting for clk.
REQ-033 First o_pc_valid=1 SHALL appear on the second posedge after reset deassertion, with o_pc=RESET_VECTOR_P.

Verification
REQ-034 Reset, ready=1 for 4 cycles -> o_pc sequence 0x0,0x4,0x8,0xC after BOOT cycle; valid low in BOOT.
REQ-035 o_pc=0x10, ready=0 for 3 cycles then stall=1 with ready=1 -> o_pc holds 0x10, valid stays 1.
REQ-036 o_pc=0x20, redirect to 0x200 with ready=0 -> o_pc=0x200 next cycle; redirect to 0x202 -> o_pc=TRAP_VECTOR_P, o_epc=0x20, o_misaligned one-cycle pulse.
REQ-037 o_pc=0x40, trap+mret+redirect same cycle -> o_pc=0x100, o_epc=0x40; next mret -> o_pc=0x40.
REQ-038 o_pc=0xFFFF_FFFC, accepted -> o_pc=0x0000_0000; then halt -> valid=0, o_pc frozen; resume -> valid=1 next cycle.
REQ-039 Assert reset asynchronously between clock edges while o_pc=0x80 -> outputs reach reset values before next posedge.

Source files
------------

// File: rtl/pc_sequencer_if.sv
// Fetch-address interface between the PC sequencer (master) and the fetch/control side (slave).
interface pc_sequencer_if #(
    parameter int unsigned DATA_WIDTH_P = 32
);
    logic                    i_pc_ready;
    logic                    i_stall;
    logic                    i_redirect_valid;
    logic [DATA_WIDTH_P-1:0] i_redirect_target;
    logic                    i_trap;
    logic                    i_mret;
    logic                    i_halt;
    logic                    i_resume;
    logic [DATA_WIDTH_P-1:0] o_pc;
    logic                    o_pc_valid;
    logic [DATA_WIDTH_P-1:0] o_epc;
    logic                    o_misaligned;

    modport master (
        input  i_pc_ready, i_stall, i_redirect_valid, i_redirect_target,
        input  i_trap, i_mret, i_halt, i_resume,
        output o_pc, o_pc_valid, o_epc, o_misaligned
    );

    modport slave (
        output i_pc_ready, i_stall, i_redirect_valid, i_redirect_target,
        output i_trap, i_mret, i_halt, i_resume,
        input  o_pc, o_pc_valid, o_epc, o_misaligned
    );
endinterface

// File: rtl/pc_sequencer.sv
// Program-counter sequencer: BOOT/RUN/HALTED control with trap > mret > redirect > advance priority.
module pc_sequencer #(
    parameter int unsigned             DATA_WIDTH_P   = 32,
    parameter logic [DATA_WIDTH_P-1:0] RESET_VECTOR_P = '0,
    parameter logic [DATA_WIDTH_P-1:0] TRAP_VECTOR_P  = DATA_WIDTH_P'(32'h0000_0100),
    parameter int unsigned             INSTR_BYTES_P  = 4
) (
    input logic            clk,
    input logic            reset,
    pc_sequencer_if.master bus
);
    localparam int unsigned ALIGN_BITS = $clog2(INSTR_BYTES_P);
    localparam logic [DATA_WIDTH_P-1:0] PC_STEP = DATA_WIDTH_P'(INSTR_BYTES_P);

    typedef enum logic [1:0] {
        BOOT,
        RUN,
        HALTED
    } state_t;

    state_t                  state;
    logic                    boot_armed;
    logic [DATA_WIDTH_P-1:0] pc_q;
    logic [DATA_WIDTH_P-1:0] epc_q;
    logic                    valid_q;
    logic                    misaligned_q;

    logic bad_redirect;
    logic take_trap;
    logic advance;

    assign bad_redirect = bus.i_redirect_valid & (|bus.i_redirect_target[ALIGN_BITS-1:0]);
    assign take_trap    = bus.i_trap | bad_redirect;
    assign advance      = valid_q & bus.i_pc_ready & ~bus.i_stall;

    // The first edge after reset release only arms BOOT, so valid first shows on the second edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= BOOT;
            boot_armed   <= 1'b0;
            pc_q         <= RESET_VECTOR_P;
            epc_q        <= '0;
            valid_q      <= 1'b0;
            misaligned_q <= 1'b0;
        end else begin
            misaligned_q <= 1'b0;
            case (state)
                BOOT: begin
                    boot_armed <= 1'b1;
                    if (boot_armed) begin
                        state   <= RUN;
                        valid_q <= 1'b1;
                    end
                end
                RUN, HALTED: begin
                    if (take_trap) begin
                        epc_q        <= pc_q;
                        pc_q         <= TRAP_VECTOR_P;
                        misaligned_q <= bad_redirect;
                    end else if (bus.i_mret) begin
                        pc_q <= epc_q;
                    end else if (bus.i_redirect_valid) begin
                        pc_q <= bus.i_redirect_target;
                    end else if (state == RUN && advance) begin
                        pc_q <= pc_q + PC_STEP;
                    end

                    // Resume takes precedence over a concurrent halt while halted.
                    if (state == RUN && bus.i_halt) begin
                        state   <= HALTED;
                        valid_q <= 1'b0;
                    end else if (state == HALTED && bus.i_resume) begin
                        state   <= RUN;
                        valid_q <= 1'b1;
                    end
                end
                default: begin
                    state   <= BOOT;
                    valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.o_pc         = pc_q;
    assign bus.o_pc_valid   = valid_q;
    assign bus.o_epc        = epc_q;
    assign bus.o_misaligned = misaligned_q;
endmodule

// File: tb/tb_pc_sequencer.sv
// Directed self-checking bench for pc_sequencer with hand-computed expected values.
module tb_pc_sequencer;
    logic clk;
    logic reset;
    int   n_cmp;
    int   n_bad;

    pc_sequencer_if #(.DATA_WIDTH_P(32)) bus ();

    pc_sequencer #(
        .DATA_WIDTH_P  (32),
        .RESET_VECTOR_P(32'h0000_0000),
        .TRAP_VECTOR_P (32'h0000_0100),
        .INSTR_BYTES_P (4)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        bus.i_pc_ready        = 1'b0;
        bus.i_stall           = 1'b0;
        bus.i_redirect_valid  = 1'b0;
        bus.i_redirect_target = '0;
        bus.i_trap            = 1'b0;
        bus.i_mret            = 1'b0;
        bus.i_halt            = 1'b0;
        bus.i_resume          = 1'b0;
    endtask

    task automatic redirect_to(input logic [31:0] tgt);
        bus.i_redirect_valid  = 1'b1;
        bus.i_redirect_target = tgt;
        step();
        bus.i_redirect_valid  = 1'b0;
    endtask

    task automatic test_reset();
        clear_inputs();
        reset = 1'b0;
        #2 reset = 1'b1;
        #1;
        n_cmp++; if (bus.o_pc !== 32'h0)     begin n_bad++; $display("FAIL reset_pc got %h want %h", bus.o_pc, 32'h0); end
        n_cmp++; if (bus.o_pc_valid !== 1'b0) begin n_bad++; $display("FAIL reset_valid got %b want 0", bus.o_pc_valid); end
        n_cmp++; if (bus.o_epc !== 32'h0)    begin n_bad++; $display("FAIL reset_epc got %h want %h", bus.o_epc, 32'h0); end
        n_cmp++; if (bus.o_misaligned !== 1'b0) begin n_bad++; $display("FAIL reset_mis got %b want 0", bus.o_misaligned); end
        step();
        step();
        reset = 1'b0;
    endtask

    task automatic test_boot_and_advance();
        // Inputs during BOOT must be ignored.
        bus.i_pc_ready        = 1'b1;
        bus.i_redirect_valid  = 1'b1;
        bus.i_redirect_target = 32'h300;
        step();
        n_cmp++; if (bus.o_pc_valid !== 1'b0) begin n_bad++; $display("FAIL boot_valid got %b want 0", bus.o_pc_valid); end
        n_cmp++; if (bus.o_pc !== 32'h0)      begin n_bad++; $display("FAIL boot_pc got %h want 0", bus.o_pc); end
        step();
        bus.i_redirect_valid = 1'b0;
        n_cmp++; if (bus.o_pc_valid !== 1'b1) begin n_bad++; $display("FAIL first_valid got %b want 1", bus.o_pc_valid); end
        n_cmp++; if (bus.o_pc !== 32'h0)      begin n_bad++; $display("FAIL first_pc got %h want 0", bus.o_pc); end
        for (int i = 1; i <= 4; i++) begin
            step();
            n_cmp++;
            if (bus.o_pc !== 32'(4 * i)) begin
                n_bad++; $display("FAIL seq_pc[%0d] got %h want %h", i, bus.o_pc, 32'(4 * i));
            end
        end
    endtask

    task automatic test_hold();
        bus.i_pc_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            n_cmp++; if (bus.o_pc !== 32'h10 || bus.o_pc_valid !== 1'b1) begin
                n_bad++; $display("FAIL hold_ready[%0d] got pc=%h v=%b want pc=10 v=1", i, bus.o_pc, bus.o_pc_valid);
            end
        end
        bus.i_pc_ready = 1'b1;
        bus.i_stall    = 1'b1;
        step();
        n_cmp++; if (bus.o_pc !== 32'h10 || bus.o_pc_valid !== 1'b1) begin
            n_bad++; $display("FAIL hold_stall got pc=%h v=%b want pc=10 v=1", bus.o_pc, bus.o_pc_valid);
        end
        bus.i_stall    = 1'b0;
        bus.i_pc_ready = 1'b0;
    endtask

    task automatic test_redirect();
        bus.i_stall = 1'b1;
        redirect_to(32'h20);
        n_cmp++; if (bus.o_pc !== 32'h20) begin n_bad++; $display("FAIL redir_stall got %h want 20", bus.o_pc); end
        bus.i_stall = 1'b0;
        redirect_to(32'h200);
        n_cmp++; if (bus.o_pc !== 32'h200) begin n_bad++; $display("FAIL redir_200 got %h want 200", bus.o_pc); end
        n_cmp++; if (bus.o_misaligned !== 1'b0) begin n_bad++; $display("FAIL redir_nomis got %b want 0", bus.o_misaligned); end
        redirect_to(32'h20);
        redirect_to(32'h202);
        n_cmp++; if (bus.o_pc !== 32'h100) begin n_bad++; $display("FAIL mis_pc got %h want 100", bus.o_pc); end
        n_cmp++; if (bus.o_epc !== 32'h20) begin n_bad++; $display("FAIL mis_epc got %h want 20", bus.o_epc); end
        n_cmp++; if (bus.o_misaligned !== 1'b1) begin n_bad++; $display("FAIL mis_pulse got %b want 1", bus.o_misaligned); end
        step();
        n_cmp++; if (bus.o_misaligned !== 1'b0) begin n_bad++; $display("FAIL mis_clear got %b want 0", bus.o_misaligned); end
        n_cmp++; if (bus.o_pc !== 32'h100) begin n_bad++; $display("FAIL mis_hold got %h want 100", bus.o_pc); end
    endtask

    task automatic test_trap_priority();
        redirect_to(32'h40);
        bus.i_trap            = 1'b1;
        bus.i_mret            = 1'b1;
        bus.i_redirect_valid  = 1'b1;
        bus.i_redirect_target = 32'h80;
        step();
        clear_inputs();
        n_cmp++; if (bus.o_pc !== 32'h100) begin n_bad++; $display("FAIL prio_pc got %h want 100", bus.o_pc); end
        n_cmp++; if (bus.o_epc !== 32'h40) begin n_bad++; $display("FAIL prio_epc got %h want 40", bus.o_epc); end
        bus.i_mret = 1'b1;
        step();
        bus.i_mret = 1'b0;
        n_cmp++; if (bus.o_pc !== 32'h40)  begin n_bad++; $display("FAIL mret_pc got %h want 40", bus.o_pc); end
        n_cmp++; if (bus.o_epc !== 32'h40) begin n_bad++; $display("FAIL mret_epc got %h want 40", bus.o_epc); end
    endtask

    task automatic test_wrap_halt();
        bus.i_resume = 1'b1;
        redirect_to(32'hFFFF_FFFC);
        bus.i_resume = 1'b0;
        n_cmp++; if (bus.o_pc_valid !== 1'b1) begin n_bad++; $display("FAIL resume_ignored got %b want 1", bus.o_pc_valid); end
        bus.i_pc_ready = 1'b1;
        step();
        n_cmp++; if (bus.o_pc !== 32'h0) begin n_bad++; $display("FAIL wrap_pc got %h want 0", bus.o_pc); end
        bus.i_halt = 1'b1;
        step();
        bus.i_halt = 1'b0;
        n_cmp++; if (bus.o_pc !== 32'h4 || bus.o_pc_valid !== 1'b0) begin
            n_bad++; $display("FAIL halt_entry got pc=%h v=%b want pc=4 v=0", bus.o_pc, bus.o_pc_valid);
        end
        step();
        n_cmp++; if (bus.o_pc !== 32'h4 || bus.o_pc_valid !== 1'b0) begin
            n_bad++; $display("FAIL halt_frozen got pc=%h v=%b want pc=4 v=0", bus.o_pc, bus.o_pc_valid);
        end
        bus.i_pc_ready = 1'b0;
        redirect_to(32'h60);
        n_cmp++; if (bus.o_pc !== 32'h60 || bus.o_pc_valid !== 1'b0) begin
            n_bad++; $display("FAIL halt_redir got pc=%h v=%b want pc=60 v=0", bus.o_pc, bus.o_pc_valid);
        end
        bus.i_halt   = 1'b1;
        bus.i_resume = 1'b1;
        step();
        bus.i_halt   = 1'b0;
        bus.i_resume = 1'b0;
        n_cmp++; if (bus.o_pc !== 32'h60 || bus.o_pc_valid !== 1'b1) begin
            n_bad++; $display("FAIL resume got pc=%h v=%b want pc=60 v=1", bus.o_pc, bus.o_pc_valid);
        end
    endtask

    task automatic test_async_reset();
        redirect_to(32'h80);
        n_cmp++; if (bus.o_pc !== 32'h80) begin n_bad++; $display("FAIL pre_rst_pc got %h want 80", bus.o_pc); end
        #2 reset = 1'b1;
        #1;
        n_cmp++; if (bus.o_pc !== 32'h0 || bus.o_pc_valid !== 1'b0) begin
            n_bad++; $display("FAIL async_rst got pc=%h v=%b want pc=0 v=0", bus.o_pc, bus.o_pc_valid);
        end
        n_cmp++; if (bus.o_epc !== 32'h0 || bus.o_misaligned !== 1'b0) begin
            n_bad++; $display("FAIL async_rst_epc got epc=%h m=%b want epc=0 m=0", bus.o_epc, bus.o_misaligned);
        end
        step();
        reset = 1'b0;
        step();
        n_cmp++; if (bus.o_pc_valid !== 1'b0) begin n_bad++; $display("FAIL reboot_boot got %b want 0", bus.o_pc_valid); end
        step();
        n_cmp++; if (bus.o_pc_valid !== 1'b1 || bus.o_pc !== 32'h0) begin
            n_bad++; $display("FAIL reboot_run got pc=%h v=%b want pc=0 v=1", bus.o_pc, bus.o_pc_valid);
        end
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        test_reset();
        test_boot_and_advance();
        test_hold();
        test_redirect();
        test_trap_priority();
        test_wrap_halt();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
